// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder:
// segment bit positions, the hex pattern table, FSM encoding and sample payload.
package seg7_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned AN_W       = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned CNT_W      = 4;

   // Bit positions within a segment word (a is the MSB).
   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

   // Lit-segment pattern for each hex value, indexed by that value.
   localparam logic [SEG_W-1:0] SEG_PATTERNS [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_e;

   typedef struct packed {
      logic [SEG_W-1:0] seg;
      logic [AN_W-1:0]  an;
   } sample_t;

   function automatic logic is_onehot(input logic [AN_W-1:0] v);
      return (v != '0) && ((v & (v - AN_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse seven-segment lookup: pattern to hex value plus valid.
module seg7_pattern_decoder
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] pattern_i,
   output logic [NIB_W-1:0] value_c_o,
   output logic             valid_c_o
);

   always_comb begin
      value_c_o = '0;
      valid_c_o = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern_i == SEG_PATTERNS[i]) begin
            value_c_o = NIB_W'(i);
            valid_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex frame from a multiplexed seven-segment display scan,
// accepting each digit only after its segment/enable lines have settled.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [SEG_W-1:0]            seg,
   input  logic [AN_W-1:0]             an,
   output logic [NUM_DIGITS*NIB_W-1:0] digits,
   output logic [NUM_DIGITS-1:0]       digit_err,
   output logic                        frame_done,
   output logic                        busy
);

   sample_t                       smp_q, prv_q;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   state_e                        state_q, state_d;
   logic [NUM_DIGITS*NIB_W-1:0]   shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]         serr_q, serr_d;
   logic [NUM_DIGITS-1:0]         mask_q, mask_d;
   logic [NUM_DIGITS*NIB_W-1:0]   digits_q, digits_d;
   logic [NUM_DIGITS-1:0]         derr_q, derr_d;
   logic                          done_q, done_d;
   logic                          busy_q;
   logic                          onehot_c, accept_c;
   logic [NIB_W-1:0]              dec_value_c;
   logic                          dec_valid_c;

   assign onehot_c = is_onehot(smp_q.an);

   // Stability count for the current registered sample.
   always_comb begin
      cnt_d = '0;
      if (onehot_c) begin
         if (smp_q != prv_q)
            cnt_d = CNT_W'(1);
         else if (cnt_q < CNT_W'(STABLE_CYCLES))
            cnt_d = cnt_q + CNT_W'(1);
         else
            cnt_d = cnt_q;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      if (!onehot_c) begin
         state_d = ST_WAIT;
      end else begin
         case (state_q)
            ST_WAIT:   if (cnt_d == CNT_W'(1)) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_d == CNT_W'(STABLE_CYCLES)) state_d = ST_HELD;
            ST_HELD:   if (cnt_d == CNT_W'(1)) state_d = ST_SETTLE;
            default:   state_d = ST_WAIT;
         endcase
      end
   end

   // FSM output: one acceptance per entry into HELD.
   always_comb begin
      accept_c = (state_q == ST_SETTLE) && (state_d == ST_HELD);
   end

   seg7_pattern_decoder u_dec (
      .pattern_i (smp_q.seg),
      .value_c_o (dec_value_c),
      .valid_c_o (dec_valid_c)
   );

   // Shadow frame assembly; the completing write is merged into the outputs.
   always_comb begin
      shadow_d = shadow_q;
      serr_d   = serr_q;
      mask_d   = mask_q;
      digits_d = digits_q;
      derr_d   = derr_q;
      done_d   = 1'b0;
      if (accept_c) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (smp_q.an[i]) begin
               shadow_d[i*NIB_W +: NIB_W] = dec_valid_c ? dec_value_c : '0;
               serr_d[i]                  = ~dec_valid_c;
               mask_d[i]                  = 1'b1;
            end
         end
         if (mask_d == '1) begin
            digits_d = shadow_d;
            derr_d   = serr_d;
            done_d   = 1'b1;
            mask_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q    <= '0;
         prv_q    <= '0;
         cnt_q    <= '0;
         state_q  <= ST_WAIT;
         shadow_q <= '0;
         serr_q   <= '0;
         mask_q   <= '0;
         digits_q <= '0;
         derr_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         smp_q    <= '{seg: seg, an: an};
         prv_q    <= smp_q;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         shadow_q <= shadow_d;
         serr_q   <= serr_d;
         mask_q   <= mask_d;
         digits_q <= digits_d;
         derr_q   <= derr_d;
         done_q   <= done_d;
         busy_q   <= (state_d == ST_SETTLE);
      end
   end

   assign digits     = digits_q;
   assign digit_err  = derr_q;
   assign frame_done = done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scenario bench for seg7_scan_decoder with hand-computed frames.
module tb_seg7_scan_decoder;

   logic        clk;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  digit_err;
   logic        frame_done;
   logic        busy;

   int n_checks;
   int n_pass;
   int fd_cnt;

   seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg        (seg),
      .an         (an),
      .digits     (digits),
      .digit_err  (digit_err),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // frame_done is stable across the posedge, so count pulses there.
   always @(posedge clk) if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;

   // Present one digit for n cycles; starts and ends on a negedge.
   task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; an = 4'h0; seg = 7'h00;
      repeat (3) @(negedge clk);
      n_checks++; if (digits !== 16'h0000) $display("FAIL reset_digits got %h want 0000", digits); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL reset_err got %b want 0000", digit_err); else n_pass++;
      n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_scan();
      fd_cnt = 0;
      show(4'b0001, 7'h30, 6);
      show(4'b0010, 7'h6D, 6);
      show(4'b0100, 7'h79, 6);
      n_checks++; if (digits !== 16'h0000) $display("FAIL partial_hidden got %h want 0000", digits); else n_pass++;
      show(4'b1000, 7'h33, 6);
      n_checks++; if (fd_cnt !== 1) $display("FAIL basic_fd_count got %0d want 1", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'h4321) $display("FAIL basic_digits got %h want 4321", digits); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL basic_err got %b want 0000", digit_err); else n_pass++;
      n_checks++; if (frame_done !== 1'b0) $display("FAIL basic_fd_pulse got %b want 0", frame_done); else n_pass++;
   endtask

   task automatic test_invalid_digit();
      fd_cnt = 0;
      show(4'b0001, 7'h70, 6);
      show(4'b0010, 7'h49, 6);
      show(4'b0100, 7'h4E, 6);
      show(4'b1000, 7'h4F, 6);
      n_checks++; if (fd_cnt !== 1) $display("FAIL invalid_fd_count got %0d want 1", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'hEC07) $display("FAIL invalid_digits got %h want EC07", digits); else n_pass++;
      n_checks++; if (digit_err !== 4'b0010) $display("FAIL invalid_err got %b want 0010", digit_err); else n_pass++;
   endtask

   task automatic test_settle_restart();
      fd_cnt = 0;
      show(4'b0001, 7'h7E, 6);
      show(4'b0010, 7'h73, 6);
      an = 4'b0100; seg = 7'h7F;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            n_checks++; if (busy !== 1'b1) $display("FAIL glitch_busy cyc %0d got %b want 1", i, busy); else n_pass++;
         end
      end
      seg = 7'h79;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i <= 4) begin
            n_checks++; if (busy !== 1'b1) $display("FAIL restart_busy cyc %0d got %b want 1", i, busy); else n_pass++;
         end else begin
            n_checks++; if (busy !== 1'b0) $display("FAIL held_busy cyc %0d got %b want 0", i, busy); else n_pass++;
         end
      end
      show(4'b1000, 7'h1F, 6);
      n_checks++; if (fd_cnt !== 1) $display("FAIL restart_fd_count got %0d want 1", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'hB390) $display("FAIL restart_digits got %h want B390", digits); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL restart_err got %b want 0000", digit_err); else n_pass++;
   endtask

   task automatic test_multi_hot();
      fd_cnt = 0;
      show(4'b0001, 7'h30, 6);
      an = 4'b0011; seg = 7'h7F;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            n_checks++; if (busy !== 1'b0) $display("FAIL multihot_busy cyc %0d got %b want 0", i, busy); else n_pass++;
         end
      end
      n_checks++; if (fd_cnt !== 0) $display("FAIL multihot_fd_early got %0d want 0", fd_cnt); else n_pass++;
      show(4'b0010, 7'h6D, 6);
      show(4'b0100, 7'h79, 6);
      show(4'b1000, 7'h33, 6);
      n_checks++; if (fd_cnt !== 1) $display("FAIL multihot_fd_count got %0d want 1", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'h4321) $display("FAIL multihot_digits got %h want 4321", digits); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      show(4'b0001, 7'h73, 6);
      show(4'b0010, 7'h7F, 6);
      show(4'b0100, 7'h70, 6);
      rst = 1'b1; an = 4'h0; seg = 7'h00;
      @(negedge clk);
      rst = 1'b0;
      fd_cnt = 0;
      n_checks++; if (digits !== 16'h0000) $display("FAIL midrst_digits got %h want 0000", digits); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL midrst_err got %b want 0000", digit_err); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
      @(negedge clk);
      show(4'b0001, 7'h5B, 6);
      show(4'b0010, 7'h5F, 6);
      show(4'b0100, 7'h3D, 6);
      n_checks++; if (fd_cnt !== 0) $display("FAIL midrst_fd_early got %0d want 0", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'h0000) $display("FAIL midrst_partial got %h want 0000", digits); else n_pass++;
      show(4'b1000, 7'h47, 6);
      n_checks++; if (fd_cnt !== 1) $display("FAIL midrst_fd_count got %0d want 1", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'hFD65) $display("FAIL midrst_digits_new got %h want FD65", digits); else n_pass++;
   endtask

   task automatic test_overwrite();
      fd_cnt = 0;
      show(4'b0001, 7'h5B, 6);
      show(4'b0001, 7'h77, 6);
      show(4'b0010, 7'h7E, 6);
      show(4'b0100, 7'h30, 6);
      n_checks++; if (fd_cnt !== 0) $display("FAIL overwrite_fd_early got %0d want 0", fd_cnt); else n_pass++;
      show(4'b1000, 7'h6D, 6);
      n_checks++; if (fd_cnt !== 1) $display("FAIL overwrite_fd_count got %0d want 1", fd_cnt); else n_pass++;
      n_checks++; if (digits !== 16'h210A) $display("FAIL overwrite_digits got %h want 210A", digits); else n_pass++;
      n_checks++; if (digit_err !== 4'h0) $display("FAIL overwrite_err got %b want 0000", digit_err); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      fd_cnt   = 0;
      rst = 1'b1; an = 4'h0; seg = 7'h00;
      @(negedge clk);
      test_reset();
      test_basic_scan();
      test_invalid_digit();
      test_settle_restart();
      test_multi_hot();
      test_reset_mid_frame();
      test_overwrite();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
